// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared types and defaults for the two-requester adder arbiter
package add_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/add_flag_unit.sv
// rtl/add_flag_unit.sv - combinational adder producing sum and Z/V/N flags
module add_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             v,
  output logic             n
);

  logic [WIDTH:0] sum_ext;
  logic           signed_ovf;

  // One shared adder; carry-out gives unsigned overflow, operand/result sign
  // bits give signed overflow, and N reports the sign of the exact sum.
  always_comb begin
    sum_ext    = {1'b0, a} + {1'b0, b};
    s          = sum_ext[WIDTH-1:0];
    z          = (s == '0);
    signed_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    if (sign) begin
      v = signed_ovf;
      n = s[WIDTH-1] ^ signed_ovf;
    end else begin
      v = sum_ext[WIDTH];
      n = 1'b0;
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter sharing one adder and one result register
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sign,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sign,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_z,
  output logic             rsp_v,
  output logic             rsp_n,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_n;
  req_id_t          last_grant, grant;
  logic             accept, take;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sign;
  logic [WIDTH-1:0] fu_s;
  logic             fu_z, fu_v, fu_n;

  // Grant and handshake: ties go to the requester not served last; reset
  // suppresses every ready so nothing is accepted while it is asserted.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    accept     = !reset && ((state == EMPTY) || rsp_ready);
    req0_ready = accept && (grant == 1'b0) && req0_valid;
    req1_ready = accept && (grant == 1'b1) && req1_valid;
    take       = req0_ready || req1_ready;
    op_a       = grant ? req1_a    : req0_a;
    op_b       = grant ? req1_b    : req0_b;
    op_sign    = grant ? req1_sign : req0_sign;
  end

  add_flag_unit #(.WIDTH(WIDTH)) u_flag (
    .a    (op_a),
    .b    (op_b),
    .sign (op_sign),
    .s    (fu_s),
    .z    (fu_z),
    .v    (fu_v),
    .n    (fu_n)
  );

  // State register for the result-holding FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next state: any accepted op fills the register; an unrefilled drain empties it.
  always_comb begin
    state_n = state;
    case (state)
      EMPTY: if (take) state_n = FULL;
      FULL: begin
        if (take) begin
          state_n = FULL;
        end else if (rsp_ready) begin
          state_n = EMPTY;
        end
      end
    endcase
  end

  assign rsp_valid = (state == FULL);

  // Result register, round-robin memory and saturating overflow counter,
  // all updated only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id     <= 1'b0;
      rsp_s      <= '0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_n      <= 1'b0;
      ovf_count  <= '0;
      last_grant <= 1'b1;
    end else if (take) begin
      rsp_id     <= grant;
      rsp_s      <= fu_s;
      rsp_z      <= fu_z;
      rsp_v      <= fu_v;
      rsp_n      <= fu_n;
      last_grant <= grant;
      if (fu_v && (ovf_count != CNT_MAX)) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - self-checking bench for add_arbiter
module tb_add_arbiter;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req0_sign;
  logic [W-1:0]  req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_sign;
  logic [W-1:0]  req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]  rsp_s;
  logic          rsp_z, rsp_v, rsp_n;
  logic [CW-1:0] ovf_count;

  always #5 clk = ~clk;

  add_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sign  (req0_sign),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sign  (req1_sign),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_z      (rsp_z),
    .rsp_v      (rsp_v),
    .rsp_n      (rsp_n),
    .ovf_count  (ovf_count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic z, v, n;
  } res_t;

  typedef struct {
    logic         id;
    logic [W-1:0] a, b;
    logic         sign;
    logic [W-1:0] s;
    logic         z, v, n;
    int           cnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference add from exact integer arithmetic rather than bit rules.
  function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    res_t   r;
    longint ex;
    if (sg) begin
      ex  = longint'($signed(a)) + longint'($signed(b));
      r.v = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
      r.n = (ex < 0);
    end else begin
      ex  = longint'({32'd0, a}) + longint'({32'd0, b});
      r.v = (ex >= 64'sd4294967296);
      r.n = 1'b0;
    end
    r.s = ex[W-1:0];
    r.z = (r.s == '0);
    return r;
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_sign = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_sign = 0;
    rsp_ready  = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    reset = 1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 0;
  endtask

  function automatic logic [W-1:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  vec_t vecs[10];

  // Random-phase model state
  logic         m_valid, m_id, m_last;
  res_t         m_res;
  int           m_cnt, w0, w1;
  logic         e0, e1, acc, g;

  initial begin
    reset = 1;
    idle_inputs();

    vecs[0] = '{0, 32'd5,          32'd7,          1, 32'd12,         0, 0, 0, 0};
    vecs[1] = '{1, 32'h7FFF_FFFF,  32'd1,          1, 32'h8000_0000,  0, 1, 0, 1};
    vecs[2] = '{0, 32'hFFFF_FFFF,  32'd1,          0, 32'h0,          1, 1, 0, 2};
    vecs[3] = '{1, 32'h8000_0000,  32'h8000_0000,  1, 32'h0,          1, 1, 1, 3};
    vecs[4] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, 32'hFFFF_FFFE,  0, 0, 1, 3};
    vecs[5] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 32'hFFFF_FFFE,  0, 1, 0, 4};
    vecs[6] = '{0, 32'd3,          32'hFFFF_FFFD,  1, 32'h0,          1, 0, 0, 4};
    vecs[7] = '{1, 32'h4000_0000,  32'h4000_0000,  1, 32'h8000_0000,  0, 1, 0, 5};
    vecs[8] = '{0, 32'h4000_0000,  32'h4000_0000,  0, 32'h8000_0000,  0, 0, 0, 5};
    vecs[9] = '{1, 32'h0,          32'h0,          0, 32'h0,          1, 0, 0, 5};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id",    64'(rsp_id),    64'd0);
    chk("reset_rsp_s",     64'(rsp_s),     64'd0);
    chk("reset_flags",     64'({rsp_z, rsp_v, rsp_n}), 64'd0);
    chk("reset_ovf",       64'(ovf_count), 64'd0);

    // Table-driven single operations, latency one
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      idle_inputs();
      rsp_ready = 1;
      if (vecs[i].id) begin
        req1_valid = 1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_sign = vecs[i].sign;
      end else begin
        req0_valid = 1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_sign = vecs[i].sign;
      end
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 64'({req1_ready, req0_ready}),
          vecs[i].id ? 64'd2 : 64'd1);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("vec%0d_id", i),    64'(rsp_id),    64'(vecs[i].id));
      chk($sformatf("vec%0d_s", i),     64'(rsp_s),     64'(vecs[i].s));
      chk($sformatf("vec%0d_zvn", i),   64'({rsp_z, rsp_v, rsp_n}),
          64'({vecs[i].z, vecs[i].v, vecs[i].n}));
      chk($sformatf("vec%0d_ovf", i),   64'(ovf_count), 64'(vecs[i].cnt));
    end

    // Alternating grants with both requesters always valid
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_sign = 0;
    req1_valid = 1; req1_a = 32'd2; req1_b = 32'd2; req1_sign = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("alt%0d_ready", k), 64'({req1_ready, req0_ready}),
          (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0) begin
        chk($sformatf("alt%0d_rsp_valid", k), 64'(rsp_valid), 64'd1);
        chk($sformatf("alt%0d_rsp_id", k),    64'(rsp_id),    64'((k - 1) % 2));
      end
      @(posedge clk); #1;
    end

    // Back-pressure: held result stays stable, no requester is served
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_ready", k), 64'({req1_ready, req0_ready}), 64'd0);
      chk($sformatf("hold%0d_rsp", k),   64'({rsp_valid, rsp_id, rsp_s}), {31'd0, 1'b1, 1'b1, 32'd4});
      @(posedge clk); #1;
    end
    req0_valid = 0;
    req1_a = 32'd10; req1_b = 32'd20;
    rsp_ready = 1;
    @(negedge clk);
    chk("refill_ready", 64'({req1_ready, req0_ready}), 64'd2);
    chk("refill_old_s", 64'(rsp_s), 64'd4);
    @(posedge clk); #1;
    req1_valid = 0;
    @(negedge clk);
    chk("refill_new", 64'({rsp_valid, rsp_id, rsp_s}), {31'd0, 1'b1, 1'b1, 32'd30});

    // Reset while holding a result with a request pending
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_sign = 1;
    rsp_ready = 1;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(req0_ready), 64'd0);
    chk("rst_mid_pre",   64'({rsp_valid, ovf_count}), 64'({1'b1, CW'(1)}));
    @(posedge clk); #1;
    reset = 0; req0_valid = 0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_ovf",   64'(ovf_count), 64'd0);

    // Counter saturation under back-to-back overflowing ops
    @(posedge clk); #1;
    rsp_ready = 1;
    req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_sign = 0;
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d", n), 64'(ovf_count), (n < int'(CMAX)) ? 64'(n) : 64'(CMAX));
    end

    // Randomised traffic against the exact-arithmetic model
    do_reset();
    m_valid = 0; m_id = 0; m_last = 1; m_res = '0; m_cnt = 0; w0 = 0; w1 = 0;
    e0 = 0; e1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || e0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = pick_op(); req0_b = pick_op(); req0_sign = 1'($urandom);
      end
      if (!req1_valid || e1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = pick_op(); req1_b = pick_op(); req1_sign = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = !m_valid || rsp_ready;
      g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e0  = acc && req0_valid && !g;
      e1  = acc && req1_valid && g;
      chk("rnd_ready", 64'({req1_ready, req0_ready}), 64'({e1, e0}));
      chk("rnd_valid", 64'(rsp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_rsp", 64'({rsp_id, rsp_s, rsp_z, rsp_v, rsp_n}),
            64'({m_id, m_res.s, m_res.z, m_res.v, m_res.n}));
      end
      chk("rnd_ovf", 64'(ovf_count), 64'(m_cnt));
      if (acc && req0_valid && !e0) w0++; else if (e0) w0 = 0;
      if (acc && req1_valid && !e1) w1++; else if (e1) w1 = 0;
      if (w0 >= 2 || w1 >= 2) chk("rnd_starve", 64'({w1[7:0], w0[7:0]}), 64'd0);
      if (e0 || e1) begin
        m_valid = 1;
        m_id    = g;
        m_last  = g;
        m_res   = g ? ref_add(req1_a, req1_b, req1_sign) : ref_add(req0_a, req0_b, req0_sign);
        if (m_res.v && m_cnt < int'(CMAX)) m_cnt++;
      end else if (m_valid && rsp_ready) begin
        m_valid = 0;
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width.
REQ-002 Parameter: CNT_W, 16, width of the overflow event counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 has an operation pending.
REQ-006 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  in  WIDTH  requester 0 operands.
REQ-008 req0_sign  in  1  requester 0 signed (1) / unsigned (0) add.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sign: as REQ-005..008, for requester 1.
REQ-010 rsp_valid  out  1  result register holds a valid result.
REQ-011 rsp_ready  in  1  consumer takes result this cycle.
REQ-012 rsp_id  out  1  requester that issued the held result.
REQ-013 rsp_s  out  WIDTH  sum, modulo 2^WIDTH.
REQ-014 rsp_z, rsp_v, rsp_n  out  1 each  zero, overflow, negative flags.
REQ-015 ovf_count  out  CNT_W  count of accepted operations with V=1.

Function
REQ-016 Block SHALL share one WIDTH-bit adder between two requesters, with one result register.
REQ-017 FSM states SHALL be EMPTY (no result held) and FULL (result held); rsp_valid=1 exactly in FULL.
REQ-018 accept SHALL be true when state is EMPTY, or FULL with rsp_ready=1 (same-cycle drain and refill).
REQ-019 Only one of req0_ready/req1_ready SHALL be high per cycle; reqX_ready = accept AND grant==X AND reqX_valid.
REQ-020 Grant: only one valid -> that one; both valid -> requester not in last_grant; last_grant updates only on an accepted transfer.
REQ-021 ready SHALL be combinational from valid/state/rsp_ready; valid SHALL not depend on ready.
REQ-022 On acceptance, result and flags SHALL be registered; rsp_valid rises the next cycle (latency 1).
REQ-023 Transitions: EMPTY+accept -> FULL; FULL+rsp_ready+accept -> FULL (new data); FULL+rsp_ready+no request -> EMPTY; FULL+!rsp_ready -> FULL, outputs held stable.
REQ-024 S = A+B truncated to WIDTH; Z = (S==0) in both modes.
REQ-025 Unsigned: V = carry-out of bit WIDTH-1; N = 0.
REQ-026 Signed: V = 1 iff A[MSB]==B[MSB] and S[MSB]!=A[MSB]; N = S[MSB] XOR V (true sign of exact sum).
REQ-027 ovf_count SHALL increment by 1 per accepted op with V=1, saturating at 2^CNT_W-1.
REQ-028 A requester holding valid SHALL be granted within 2 accept cycles (no starvation).

Reset
REQ-029 On reset: state=EMPTY, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_z/v/n=0, ovf_count=0, last_grant=1 (requester 0 wins first tie).
REQ-030 reset SHALL dominate: asserted mid-operation, held result is discarded, no ready asserted that cycle, no counter increment.

Structure
REQ-031 Shared package add_arb_pkg SHALL hold the state enum (EMPTY, FULL), requester-id type, and default WIDTH/CNT_W constants.
REQ-032 One combinational sub-module add_flag_unit SHALL compute S, Z, V, N from A, B, sign; arbiter, FSM, result register and counter live in add_arbiter.

Verification
REQ-033 Reset, then req0 A=5 B=7 sign=1 -> req0_ready same cycle; next cycle rsp_valid=1, rsp_s=12, rsp_id=0, Z=V=N=0.
REQ-034 Signed 0x7FFFFFFF+1 -> S=0x80000000, V=1, N=0, ovf_count=1; unsigned 0xFFFFFFFF+1 -> S=0, Z=1, V=1, N=0, ovf_count=2.
REQ-035 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one result per cycle.
REQ-036 Hold rsp_ready=0 for 3 cycles with result FULL -> both reqX_ready=0, rsp_* stable; rsp_ready=1 with req1 valid -> drain and refill same cycle.
REQ-037 Assert reset while FULL and req0 valid -> next cycle rsp_valid=0, ovf_count=0, req0_ready=0 during reset.
REQ-038 Force ovf_count to 2^CNT_W-1 via overflowing ops -> further overflow leaves it unchanged.
